stage_m: RTL
============

Name: stage_m

Overview:
- Memory pipeline stage of the combined ARM/RISC-V 5-stage core. It sits directly downstream of the execute stage and upstream of writeback.
- Contains the E/M pipeline register and the data-memory request/acknowledge handshake with a small FSM.
- Generates store byte lanes and load extraction with sign or zero extension, and detects misaligned accesses.
- Raises StallM to the hazard unit while a data-memory access is outstanding.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ALUResultE  in  32  effective address or ALU result from execute
- WriteDataE  in  32  store data, already forwarded in execute
- RdE  in  5  destination register
- RegWriteE  in  1  register write enable
- MemWriteE  in  1  store
- ResultSrcE  in  2  result select: 00 ALU, 01 load, 10 PC+4
- PCPlus4E  in  32  link value
- MemSizeE  in  2  access size: 00 word, 01 half, 10 byte
- MemUnsignedE  in  1  zero-extend loads when 1
- ALUResultM  out  32  registered ALU result, also the forwarding source for execute
- RdM  out  5  registered destination
- RegWriteM  out  1  registered write enable, gated by misalignment
- ResultSrcM  out  2  registered result select
- PCPlus4M  out  32  registered link value
- ReadDataM  out  32  extended load data
- DataAdrM  out  32  word-aligned address {ALUResultM[31:2],2'b00}
- DataWdM  out  32  lane-replicated store data
- DataBeM  out  4  byte enables
- DataReqM  out  1  memory request
- DataWeM  out  1  1 = write
- DataRdataM  in  32  memory read word
- DataAckM  in  1  memory acknowledge; may arrive in the same cycle as the request
- StallM  out  1  to hazard unit: freeze F/D/E/M
- MisalignM  out  1  misaligned access flag

Behaviour:
- E/M register:
  - Captures all E inputs on every rising edge when StallM=0; holds while StallM=1.
  - rst clears all register fields to 0. An all-zero register means no access and no write.
- Access valid: AccM = (ResultSrcM==01 | MemWriteM) & ~MisalignM.
- Misalignment:
  - Half with addr[0]=1, or word with addr[1:0]!=0, sets MisalignM=1 (combinational, from the registered address and size).
  - On misalignment: no request is issued, RegWriteM is forced to 0, and StallM=0.
- FSM states IDLE and WAIT; reset state is IDLE.
  - IDLE with AccM=1:
    - DataReqM=1 combinationally.
    - If DataAckM=1 in the same cycle, the access completes, StallM=0, and the FSM stays in IDLE.
    - Otherwise StallM=1 and the FSM moves to WAIT.
  - WAIT:
    - DataReqM=1, StallM=1, and DataAdrM/DataWdM/DataBeM/DataWeM are held stable.
    - On DataAckM=1: StallM=0 and the FSM returns to IDLE.
  - An ack arriving while DataReqM=0 is ignored.
- ReadDataM is valid in the completing (ack) cycle, passed combinationally from DataRdataM. Writeback registers it.
- Store lanes:
  - byte: DataBeM=4'b0001<<addr[1:0], DataWdM={4{wd[7:0]}}
  - half: DataBeM=4'b0011<<addr[1:0], DataWdM={2{wd[15:0]}}
  - word: DataBeM=4'hF
  - loads: DataBeM=4'hF, DataWeM=0
- Load extraction:
  - Select byte or half by addr[1:0].
  - Sign-extend unless MemUnsignedM=1. Word loads pass through unchanged.
- Back-to-back accesses:
  - The next instruction enters M in the cycle after completion.
  - IDLE handles it with no bubble when memory acks in zero wait states.
- Reset mid-access:
  - FSM returns to IDLE, the register is cleared, and DataReqM=0 in the following cycle.
  - The abandoned request is dropped. Memory must tolerate the deassertion.
- Non-memory instructions pass through in 1 cycle with StallM=0 and DataReqM=0.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_WORD/SZ_HALF/SZ_BYTE
  - ResultSrc encodings RS_ALU/RS_LOAD/RS_PC4
  - FSM enum {M_IDLE, M_WAIT}
- Sub-module mem_align: purely combinational store lane/enable generation, load extraction/extension, and the misalignment check.
- stage_m contains the flopr-based E/M register, the FSM and the handshake.

Test Plan:
- Zero-wait load byte:
  - Stimulus: addr 0x1003, size byte, signed, DataRdataM=0x80FF_FF12, ack same cycle.
  - Response: ReadDataM=0xFFFF_FF80, StallM never asserted, DataReqM for 1 cycle.
- Two-wait store half:
  - Stimulus: addr 0x2002, WriteDataE=0x0000_BEEF, ack on the 3rd request cycle.
  - Response: DataBeM=4'b1100, DataWdM=0xBEEF_BEEF, DataWeM=1, StallM=1 for exactly 2 cycles, address stable throughout.
- Misaligned word load:
  - Stimulus: addr 0x0000_0006, RegWriteE=1.
  - Response: MisalignM=1, DataReqM=0, RegWriteM=0, StallM=0.
- Unsigned half load:
  - Stimulus: addr 0x10, MemUnsignedE=1, DataRdataM=0x1234_8001.
  - Response: ReadDataM=0x0000_8001.
- Reset in WAIT:
  - Stimulus: load issued, no ack, rst pulsed on the 2nd cycle.
  - Response: the next cycle has DataReqM=0, StallM=0, all outputs 0, FSM in IDLE.
- Back-to-back:
  - Stimulus: store to 0x0 then load from 0x4, both zero-wait.
  - Response: two consecutive DataReqM cycles, no stall, RdM/ALUResultM advance each cycle.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_pkg                                                    |
// | Purpose : Shared encodings for the memory stage: access size,        |
// |           result-select values and the handshake FSM states.         |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package mem_pkg;

  // Access size encodings (MemSize)
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Result select encodings (ResultSrc)
  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  // Data-memory handshake FSM states
  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mstate_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_align                                                  |
// | Purpose : Combinational data alignment for the memory stage: store   |
// |           lane replication and byte enables, load byte/half          |
// |           extraction with sign/zero extension, misalignment check.   |
// | Ports   : addr_lo     in  2   low address bits                       |
// |           size        in  2   access size (SZ_*)                     |
// |           is_unsigned in  1   zero-extend loads                      |
// |           is_store    in  1   access is a store                      |
// |           wd          in  32  raw store data                         |
// |           rdata       in  32  raw memory read word                   |
// |           be          out 4   byte enables                           |
// |           wdata       out 32  lane-replicated store data             |
// |           rdata_ext   out 32  extracted and extended load data       |
// |           misalign    out 1   access not naturally aligned           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic        is_store,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Misalignment: halves need addr[0]=0, words need addr[1:0]=0.
  // The unused size code 2'b11 is treated as a word.
  always_comb begin
    misalign = 1'b0;
    case (size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = addr_lo[0];
      default: misalign = (addr_lo != 2'b00);
    endcase
  end

  // Store lanes: the data is replicated so that whichever lanes are
  // enabled already carry the right bytes.
  always_comb begin
    be    = 4'hF;
    wdata = wd;
    if (is_store) begin
      case (size)
        SZ_BYTE: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{wd[7:0]}};
        end
        SZ_HALF: begin
          be    = 4'b0011 << addr_lo;
          wdata = {2{wd[15:0]}};
        end
        default: begin
          be    = 4'hF;
          wdata = wd;
        end
      endcase
    end
  end

  // Load extraction
  always_comb begin
    w_byte    = rdata[{addr_lo, 3'b000} +: 8];
    w_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = rdata;
    case (size)
      SZ_BYTE: rdata_ext = {{24{w_byte[7]  & ~is_unsigned}}, w_byte};
      SZ_HALF: rdata_ext = {{16{w_half[15] & ~is_unsigned}}, w_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule : mem_align
`default_nettype wire

// File: rtl/stage_m.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : stage_m                                                    |
// | Purpose : Memory pipeline stage. Holds the E/M pipeline register,    |
// |           drives the data-memory request/ack handshake through a     |
// |           two-state FSM, and stalls the front of the pipe while an   |
// |           access is outstanding.                                     |
// | Ports   : clk, rst            clock, synchronous active-high reset   |
// |           *E inputs           execute-stage results                  |
// |           ALUResultM..PC4M    registered E/M fields                  |
// |           ReadDataM           extended load data (ack cycle)         |
// |           DataAdrM/WdM/BeM/   data-memory request bus                |
// |           ReqM/WeM, Rdata/Ack                                        |
// |           StallM, MisalignM   hazard-unit stall, misalign flag       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module stage_m
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [4:0]      RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      MemSizeE,
  input  logic            MemUnsignedE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] ReadDataM,
  output logic [XLEN-1:0] DataAdrM,
  output logic [XLEN-1:0] DataWdM,
  output logic [3:0]      DataBeM,
  output logic            DataReqM,
  output logic            DataWeM,
  input  logic [XLEN-1:0] DataRdataM,
  input  logic            DataAckM,
  output logic            StallM,
  output logic            MisalignM
);

  // E/M register fields
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_write_data;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_mem_write;
  logic [1:0]      r_result_src;
  logic [XLEN-1:0] r_pc_plus4;
  logic [1:0]      r_mem_size;
  logic            r_mem_unsigned;

  mstate_e         r_state;
  mstate_e         w_state_nxt;

  logic            w_acc;
  logic            w_misalign;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rdata_ext;

  // Resettable, enabled pipeline register (flopenr). Holding on StallM
  // is what keeps the request bus stable while the FSM sits in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_result   <= '0;
      r_write_data   <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_mem_write    <= 1'b0;
      r_result_src   <= RS_ALU;
      r_pc_plus4     <= '0;
      r_mem_size     <= SZ_WORD;
      r_mem_unsigned <= 1'b0;
    end else if (!StallM) begin
      r_alu_result   <= ALUResultE;
      r_write_data   <= WriteDataE;
      r_rd           <= RdE;
      r_reg_write    <= RegWriteE;
      r_mem_write    <= MemWriteE;
      r_result_src   <= ResultSrcE;
      r_pc_plus4     <= PCPlus4E;
      r_mem_size     <= MemSizeE;
      r_mem_unsigned <= MemUnsignedE;
    end
  end

  mem_align u_align (
    .addr_lo     (r_alu_result[1:0]),
    .size        (r_mem_size),
    .is_unsigned (r_mem_unsigned),
    .is_store    (r_mem_write),
    .wd          (r_write_data),
    .rdata       (DataRdataM),
    .be          (w_be),
    .wdata       (w_wdata),
    .rdata_ext   (w_rdata_ext),
    .misalign    (w_misalign)
  );

  // A misaligned access is suppressed entirely, so it never requests
  // or stalls.
  assign w_acc = ((r_result_src == RS_LOAD) | r_mem_write) & ~w_misalign;

  // Handshake FSM. An ack in the request cycle completes from IDLE
  // without ever entering WAIT.
  always_comb begin
    w_state_nxt = r_state;
    DataReqM    = 1'b0;
    StallM      = 1'b0;
    case (r_state)
      M_IDLE: begin
        DataReqM = w_acc;
        if (w_acc && !DataAckM) begin
          StallM      = 1'b1;
          w_state_nxt = M_WAIT;
        end
      end
      M_WAIT: begin
        DataReqM = 1'b1;
        if (DataAckM) begin
          w_state_nxt = M_IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: begin
        w_state_nxt = M_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= M_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign ALUResultM = r_alu_result;
  assign RdM        = r_rd;
  assign RegWriteM  = r_reg_write & ~w_misalign;
  assign ResultSrcM = r_result_src;
  assign PCPlus4M   = r_pc_plus4;
  assign ReadDataM  = w_rdata_ext;
  assign MisalignM  = w_misalign;

  assign DataAdrM   = {r_alu_result[XLEN-1:2], 2'b00};
  assign DataWdM    = w_wdata;
  // Enables are idle-low so that a bubble drives nothing on the bus.
  assign DataBeM    = w_acc ? w_be : 4'h0;
  assign DataWeM    = r_mem_write;

endmodule : stage_m
`default_nettype wire
